jam_cost_arbiter: RTL and testbench

- Shares the single 8x8 cost ROM port (W/J address out, 7-bit Cost in, one-cycle read latency) between NREQ job-assignment evaluation engines.
- Grants the port in locked bursts, so one engine reads all eight costs of a permutation without interleaving.
- Arbitration between bursts is round-robin.
- Routes each returned Cost back to the engine that issued the read.

---
 rtl/jam_cost_if.sv | 19 +
 rtl/jam_cost_arbiter.sv | 103 ++++++++++
 tb/tb_jam_cost_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/jam_cost_if.sv
// jam_cost_if: engine-side request/grant bus and ROM port shared by the cost arbiter
interface jam_cost_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] w_in;
  logic [3*NREQ-1:0] j_in;
  logic [NREQ-1:0]   last;
  logic [NREQ-1:0]   gnt;
  logic [2:0]        W;
  logic [2:0]        J;
  logic              rom_en;
  logic [6:0]        Cost;
  logic [6:0]        cost_out;
  logic [NREQ-1:0]   cost_vld;
  logic              ovf;
  modport master (output req, w_in, j_in, last, Cost,
                  input gnt, W, J, rom_en, cost_out, cost_vld, ovf);
  modport slave  (input req, w_in, j_in, last, Cost,
                  output gnt, W, J, rom_en, cost_out, cost_vld, ovf);
endinterface

// File: rtl/jam_cost_arbiter.sv
// jam_cost_arbiter: round-robin burst arbiter sharing one cost ROM port between engines
module jam_cost_arbiter #(
  parameter int NREQ      = 2,
  parameter int BURST_MAX = 8
) (
  input logic       CLK,
  input logic       RST,
  jam_cost_if.slave bus
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, tag_q, tag_d, vld_q, vld_d, sel;
  logic [1:0]        rr_q, rr_d, own;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        w_q, w_d, j_q, j_d, w_sel, j_sel;
  logic [6:0]        cost_q, cost_d;
  logic              pend_q, pend_d, ovf_q, ovf_d, acc, fin, req_own, last_own;
  // decode the current owner's index and address slices from the one-hot grant
  always_comb begin
    own   = '0;
    w_sel = '0;
    j_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_q[i]) begin
        own   = 2'(i);
        w_sel = bus.w_in[3*i +: 3];
        j_sel = bus.j_in[3*i +: 3];
      end
  end
  // pick the first requester at or above rr_q, wrapping modulo NREQ
  always_comb begin
    sel = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      for (int i = 0; i < NREQ; i++)
        if (bus.req[i] && i == (int'(rr_q) + k) % NREQ) begin
          sel    = '0;
          sel[i] = 1'b1;
        end
  end
  // burst FSM, address hold and response pipeline next-state
  always_comb begin
    req_own  = |(bus.req & gnt_q);
    last_own = |(bus.last & gnt_q);
    acc      = state_q == BURST && req_own;
    fin      = acc && (last_own || cnt_q == 4'(BURST_MAX - 1));
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    cnt_d    = acc ? cnt_q + 4'd1 : cnt_q;
    ovf_d    = 1'b0;
    if (state_q == IDLE && |bus.req) begin
      state_d = BURST;
      gnt_d   = sel;
    end
    if (fin) begin
      state_d = IDLE;
      gnt_d   = '0;
      cnt_d   = '0;
      rr_d    = own == 2'(NREQ - 1) ? 2'd0 : own + 2'd1;
      ovf_d   = !last_own;
    end
    w_d    = acc ? w_sel : w_q;
    j_d    = acc ? j_sel : j_q;
    tag_d  = acc ? gnt_q : tag_q;
    pend_d = acc;
    cost_d = pend_q ? bus.Cost : cost_q;
    vld_d  = pend_q ? tag_q : '0;
  end
  // state registers; reset discards any in-flight response
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      w_q     <= '0;
      j_q     <= '0;
      tag_q   <= '0;
      pend_q  <= 1'b0;
      cost_q  <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      w_q     <= w_d;
      j_q     <= j_d;
      tag_q   <= tag_d;
      pend_q  <= pend_d;
      cost_q  <= cost_d;
      vld_q   <= vld_d;
    end
  assign bus.gnt      = gnt_q;
  assign bus.W        = w_d;
  assign bus.J        = j_d;
  assign bus.rom_en   = acc;
  assign bus.cost_out = cost_q;
  assign bus.cost_vld = vld_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_jam_cost_arbiter.sv
// tb_jam_cost_arbiter: randomized and directed check of the arbiter against a transaction-level model
module tb_jam_cost_arbiter;
  localparam int N  = 2;
  localparam int BM = 8;
  typedef struct {int due; int tag; int cost;} resp_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  jam_cost_if #(.NREQ(N)) bus();
  jam_cost_arbiter #(.NREQ(N), .BURST_MAX(BM)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  function automatic int rom_cost(int w, int j);
    return ((w ^ 5) * 16 + j + 10) % 128;
  endfunction
  always @(posedge CLK) if (bus.rom_en) bus.Cost <= 7'(rom_cost(int'(bus.W), int'(bus.J)));
  resp_t q[$];
  int checks = 0, failures = 0, cyc = 0;
  int owner = -1, beats = 0, rr = 0, wq = 0, jq = 0, last_cost = 0, ovf_m = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask
  task automatic step(input logic rst_v, input logic [N-1:0] r, input logic [3*N-1:0] w,
                      input logic [3*N-1:0] j, input logic [N-1:0] l);
    int acc, ew, ej, ev, ec;
    @(negedge CLK);
    RST = rst_v;
    bus.req = r;
    bus.w_in = w;
    bus.j_in = j;
    bus.last = l;
    #1;
    if (rst_v) begin
      owner = -1; beats = 0; rr = 0; wq = 0; jq = 0; last_cost = 0; ovf_m = 0;
      q.delete();
    end
    acc = 0;
    ew = wq;
    ej = jq;
    if (owner >= 0 && r[owner]) begin
      acc = 1;
      ew = int'(w[3*owner +: 3]);
      ej = int'(j[3*owner +: 3]);
    end
    ev = 0;
    ec = last_cost;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev = 1 << q[0].tag;
      ec = q[0].cost;
      last_cost = ec;
      void'(q.pop_front());
    end
    chk("gnt", 32'(bus.gnt), owner >= 0 ? 1 << owner : 0);
    chk("rom_en", 32'(bus.rom_en), acc);
    chk("W", 32'(bus.W), ew);
    chk("J", 32'(bus.J), ej);
    chk("cost_vld", 32'(bus.cost_vld), ev);
    chk("cost_out", 32'(bus.cost_out), ec);
    chk("ovf", 32'(bus.ovf), ovf_m);
    ovf_m = 0;
    if (!rst_v) begin
      if (owner < 0) begin
        for (int k = N - 1; k >= 0; k--)
          if (r[(rr + k) % N]) owner = (rr + k) % N;
      end else if (acc) begin
        beats++;
        wq = ew;
        jq = ej;
        q.push_back('{cyc + 2, owner, rom_cost(ew, ej)});
        if (l[owner] || beats == BM) begin
          ovf_m = l[owner] ? 0 : 1;
          rr = (owner + 1) % N;
          owner = -1;
          beats = 0;
        end
      end
    end
    cyc++;
  endtask
  initial begin
    logic [N-1:0] r, l;
    logic [3*N-1:0] w, j;
    bus.req = '0; bus.w_in = '0; bus.j_in = '0; bus.last = '0;
    repeat (2) step(1'b1, '0, '0, '0, '0);
    step(1'b0, 2'b01, 6'o05, 6'o00, 2'b00);
    for (int k = 0; k < 8; k++) step(1'b0, 2'b01, 6'o05, {3'd0, 3'(k)}, {1'b0, k == 7});
    repeat (4) step(1'b0, '0, '0, '0, '0);
    for (int k = 0; k < 40; k++) step(1'b0, 2'b11, 6'(k * 9), 6'(k * 5), {1'b0, 1'b0});
    for (int k = 0; k < 36; k++) step(1'b0, 2'b11, 6'(k * 7), 6'(k * 3), {1'b1, k % 8 == 7});
    for (int k = 0; k < 12; k++) step(1'b0, {1'b0, k > 3 && k < 7 ? 1'b0 : 1'b1}, 6'o34, 6'(k), 2'b00);
    repeat (3) step(1'b0, '0, '0, '0, '0);
    step(1'b0, 2'b01, 6'o12, 6'o03, 2'b00);
    step(1'b0, 2'b01, 6'o12, 6'o04, 2'b00);
    step(1'b1, 2'b11, 6'o12, 6'o05, 2'b00);
    repeat (4) step(1'b0, '0, '0, '0, '0);
    repeat (6) step(1'b0, 2'b11, 6'o21, 6'o43, 2'b11);
    for (int k = 0; k < 1500; k++) begin
      r = N'($urandom_range(0, 3));
      w = 6'($urandom);
      j = 6'($urandom);
      l = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      step($urandom_range(0, 400) == 0, r, w, j, l);
    end
    repeat (4) step(1'b0, '0, '0, '0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
